// File: rtl/eth_mac_stats_counter.sv
// Per-channel MAC/FIFO event counters with sticky overflow flags and a
// one-outstanding read port (request/response handshake, optional clear-on-read).
module eth_mac_stats_counter #(
  parameter int CHANNELS    = 9,
  parameter int COUNT_WIDTH = 32,
  parameter bit SATURATE    = 1'b1,
  localparam int CH_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CHANNELS-1:0]    event_in,
  input  logic                   clear_all,
  input  logic                   rd_req_valid,
  output logic                   rd_req_ready,
  input  logic [CH_WIDTH-1:0]    rd_req_ch,
  input  logic                   rd_req_clear,
  output logic                   rd_resp_valid,
  input  logic                   rd_resp_ready,
  output logic [COUNT_WIDTH-1:0] rd_resp_data,
  output logic                   rd_resp_ovf,
  output logic                   rd_resp_error,
  output logic [CHANNELS-1:0]    overflow
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [COUNT_WIDTH-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0]    ovf_q, ovf_d;
  logic [COUNT_WIDTH-1:0] data_q, data_d;
  logic                   rovf_q, rovf_d;
  logic                   err_q, err_d;

  logic                   accept;
  logic                   in_range;
  logic [31:0]            ch_ext;
  logic [COUNT_WIDTH-1:0] rd_cnt;
  logic                   rd_ovf;

  // At all-ones the counter either sticks or wraps; overflow is flagged by the caller.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    if (&v) return SATURATE ? v : '0;
    return v + COUNT_WIDTH'(1);
  endfunction

  assign ch_ext   = 32'(rd_req_ch);
  assign in_range = (ch_ext < 32'(CHANNELS));
  assign accept   = rd_req_valid && (state_q == IDLE);

  // Loop-based select keeps out-of-range indices from ever addressing the array.
  always_comb begin
    rd_cnt = '0;
    rd_ovf = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_ext == 32'(c)) begin
        rd_cnt = cnt_q[c];
        rd_ovf = ovf_q[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_d[c] = cnt_q[c];
      ovf_d[c] = ovf_q[c];
      if (clear_all || (accept && rd_req_clear && (ch_ext == 32'(c)))) begin
        cnt_d[c] = COUNT_WIDTH'(event_in[c]);
        ovf_d[c] = 1'b0;
      end else if (event_in[c]) begin
        cnt_d[c] = sat_inc(cnt_q[c]);
        if (&cnt_q[c]) ovf_d[c] = 1'b1;
      end
    end
  end

  always_comb begin
    data_d = data_q;
    rovf_d = rovf_q;
    err_d  = err_q;
    if (accept) begin
      data_d = rd_cnt;
      rovf_d = rd_ovf;
      err_d  = !in_range;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_req_valid)  state_d = RESP;
      RESP:    if (rd_resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_req_ready  = (state_q == IDLE);
    rd_resp_valid = (state_q == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ovf_q   <= '0;
      data_q  <= '0;
      rovf_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      rovf_q  <= rovf_d;
      err_q   <= err_d;
      for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  assign rd_resp_data  = data_q;
  assign rd_resp_ovf   = rovf_q;
  assign rd_resp_error = err_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_eth_mac_stats_counter.sv
// Directed bench: three instances (32-bit saturating, 8-bit saturating, 8-bit wrapping)
// share one stimulus stream; expected values are hand-computed.
module tb_eth_mac_stats_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] event_in;
  logic       clear_all;
  logic       rd_req_valid;
  logic [3:0] rd_req_ch;
  logic       rd_req_clear;
  logic       rd_resp_ready;

  logic        rdyA, vldA, rovfA, errA;
  logic [31:0] dataA;
  logic [8:0]  ovfA;
  logic        rdyS, vldS, rovfS, errS;
  logic [7:0]  dataS;
  logic [8:0]  ovfS;
  logic        rdyW, vldW, rovfW, errW;
  logic [7:0]  dataW;
  logic [8:0]  ovfW;

  logic [31:0] cA;
  logic [7:0]  cS, cW;
  logic        coA, coS, coW, ceA;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  eth_mac_stats_counter #(.CHANNELS(9), .COUNT_WIDTH(32), .SATURATE(1'b1)) dA (
    .clk(clk), .rst(rst), .event_in(event_in), .clear_all(clear_all),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rdyA), .rd_req_ch(rd_req_ch),
    .rd_req_clear(rd_req_clear), .rd_resp_valid(vldA), .rd_resp_ready(rd_resp_ready),
    .rd_resp_data(dataA), .rd_resp_ovf(rovfA), .rd_resp_error(errA), .overflow(ovfA));

  eth_mac_stats_counter #(.CHANNELS(9), .COUNT_WIDTH(8), .SATURATE(1'b1)) dS (
    .clk(clk), .rst(rst), .event_in(event_in), .clear_all(clear_all),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rdyS), .rd_req_ch(rd_req_ch),
    .rd_req_clear(rd_req_clear), .rd_resp_valid(vldS), .rd_resp_ready(rd_resp_ready),
    .rd_resp_data(dataS), .rd_resp_ovf(rovfS), .rd_resp_error(errS), .overflow(ovfS));

  eth_mac_stats_counter #(.CHANNELS(9), .COUNT_WIDTH(8), .SATURATE(1'b0)) dW (
    .clk(clk), .rst(rst), .event_in(event_in), .clear_all(clear_all),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rdyW), .rd_req_ch(rd_req_ch),
    .rd_req_clear(rd_req_clear), .rd_resp_valid(vldW), .rd_resp_ready(rd_resp_ready),
    .rd_resp_data(dataW), .rd_resp_ovf(rovfW), .rd_resp_error(errW), .overflow(ovfW));

  typedef struct {
    int     pulses;
    int     pch;
    int     rch;
    bit     clr;
    longint exp_data;
    bit     exp_err;
    bit     exp_ovf;
  } vec_t;

  vec_t vec [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic pulse(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      event_in = 9'(1) << ch;
    end
    @(negedge clk);
    event_in = '0;
  endtask

  task automatic do_clear_all();
    @(negedge clk);
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
  endtask

  task automatic do_read(input int ch, input bit clr);
    int n;
    @(negedge clk);
    rd_req_valid = 1'b1;
    rd_req_ch    = 4'(ch);
    rd_req_clear = clr;
    n = 0;
    while (!rdyA && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdyA) begin
      check("req_ready_timeout", 0, 1);
      rd_req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    rd_req_valid = 1'b0;
    rd_req_clear = 1'b0;
    check("resp_valid", vldA, 1);
    cA = dataA; coA = rovfA; ceA = errA;
    cS = dataS; coS = rovfS;
    cW = dataW; coW = rovfW;
    rd_resp_ready = 1'b1;
    @(negedge clk);
    rd_resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec[0] = '{5, 2,  2, 1'b0, 5, 1'b0, 1'b0};
    vec[1] = '{0, 2,  2, 1'b0, 5, 1'b0, 1'b0};
    vec[2] = '{0, 2,  2, 1'b1, 5, 1'b0, 1'b0};
    vec[3] = '{0, 2,  2, 1'b0, 0, 1'b0, 1'b0};
    vec[4] = '{3, 8,  8, 1'b0, 3, 1'b0, 1'b0};
    vec[5] = '{2, 0, 12, 1'b0, 0, 1'b1, 1'b0};
    vec[6] = '{0, 0,  0, 1'b1, 2, 1'b0, 1'b0};
    vec[7] = '{0, 0, 15, 1'b1, 0, 1'b1, 1'b0};
    vec[8] = '{0, 8,  8, 1'b1, 3, 1'b0, 1'b0};
    vec[9] = '{0, 8,  8, 1'b0, 0, 1'b0, 1'b0};

    rst = 1'b1; event_in = '0; clear_all = 1'b0;
    rd_req_valid = 1'b0; rd_req_ch = '0; rd_req_clear = 1'b0; rd_resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", vldA, 0);
    check("rst_resp_data", dataA, 0);
    check("rst_overflow", ovfA, 0);
    rst = 1'b0;
    check("rst_req_ready", rdyA, 1);

    for (int i = 0; i < 10; i++) begin
      if (vec[i].pulses > 0) pulse(vec[i].pch, vec[i].pulses);
      do_read(vec[i].rch, vec[i].clr);
      check($sformatf("vec%0d_data", i), cA, 64'(vec[i].exp_data));
      check($sformatf("vec%0d_err", i), ceA, 64'(vec[i].exp_err));
      check($sformatf("vec%0d_ovf", i), coA, 64'(vec[i].exp_ovf));
    end

    // Saturating vs wrapping 8-bit counters
    do_clear_all();
    pulse(0, 257);
    do_read(0, 1'b0);
    check("wrap257_data", cW, 1);
    check("wrap257_ovf", coW, 1);
    check("sat257_data", cS, 255);
    check("wide257_data", cA, 257);
    check("wide257_ovf", coA, 0);
    pulse(0, 43);
    check("sat300_overflow0", ovfS[0], 1);
    do_read(0, 1'b1);
    check("sat300_data", cS, 255);
    check("sat300_ovf", coS, 1);
    check("wrap300_data", cW, 44);
    @(negedge clk);
    check("sat_clr_overflow0", ovfS[0], 0);
    do_read(0, 1'b0);
    check("sat_after_clr_data", cS, 0);
    check("sat_after_clr_ovf", coS, 0);

    // Clear-on-read with a same-cycle event on that channel
    pulse(3, 7);
    @(negedge clk);
    check("cor_req_ready", rdyA, 1);
    rd_req_valid = 1'b1; rd_req_ch = 4'd3; rd_req_clear = 1'b1; event_in = 9'(1) << 3;
    @(negedge clk);
    rd_req_valid = 1'b0; rd_req_clear = 1'b0; event_in = '0;
    check("cor_resp_data", dataA, 7);
    rd_resp_ready = 1'b1;
    @(negedge clk);
    rd_resp_ready = 1'b0;
    do_read(3, 1'b0);
    check("cor_next_data", cA, 1);

    // clear_all beats clear-on-read; the accepted read still sees the old count
    pulse(5, 4);
    @(negedge clk);
    clear_all = 1'b1; event_in = 9'(1) << 5;
    rd_req_valid = 1'b1; rd_req_ch = 4'd5; rd_req_clear = 1'b1;
    @(negedge clk);
    clear_all = 1'b0; event_in = '0; rd_req_valid = 1'b0; rd_req_clear = 1'b0;
    check("ca_resp_data", dataA, 4);
    rd_resp_ready = 1'b1;
    @(negedge clk);
    rd_resp_ready = 1'b0;
    do_read(5, 1'b0);
    check("ca_event_kept", cA, 1);

    // clear_all while a response is pending must not disturb it
    pulse(6, 2);
    @(negedge clk);
    rd_req_valid = 1'b1; rd_req_ch = 4'd6; rd_req_clear = 1'b0;
    @(negedge clk);
    rd_req_valid = 1'b0;
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    check("ca_in_resp_data", dataA, 2);
    check("ca_in_resp_valid", vldA, 1);
    rd_resp_ready = 1'b1;
    @(negedge clk);
    rd_resp_ready = 1'b0;
    do_read(6, 1'b0);
    check("ca_in_resp_after", cA, 0);

    // Out-of-range read held under backpressure
    @(negedge clk);
    rd_req_valid = 1'b1; rd_req_ch = 4'd12;
    @(negedge clk);
    rd_req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp%0d_valid", k), vldA, 1);
      check($sformatf("bp%0d_err", k), errA, 1);
      check($sformatf("bp%0d_data", k), dataA, 0);
      check($sformatf("bp%0d_req_ready", k), rdyA, 0);
      @(negedge clk);
    end
    rd_resp_ready = 1'b1;
    @(negedge clk);
    rd_resp_ready = 1'b0;

    // Reset while a response is pending
    pulse(4, 256);
    check("pre_rst_overflowS4", ovfS[4], 1);
    pulse(1, 6);
    @(negedge clk);
    rd_req_valid = 1'b1; rd_req_ch = 4'd1;
    @(negedge clk);
    rd_req_valid = 1'b0;
    check("pre_rst_valid", vldA, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", vldA, 0);
    check("rst_mid_data", dataA, 0);
    check("rst_mid_overflowS", ovfS, 0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_req_ready", rdyA, 1);
    repeat (2) @(negedge clk);
    check("rst_no_stale_resp", vldA, 0);
    do_read(1, 1'b0);
    check("rst_ch1_data", cA, 0);
    do_read(4, 1'b0);
    check("rst_ch4_dataS", cS, 0);
    check("rst_ch4_ovfS", coS, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/eth_mac_stats_counter.md
ETH_MAC_STATS_COUNTER -- requirements
Module: eth_mac_stats_counter

Interface
REQ-001 SHALL have parameter CHANNELS, default 9: number of independent event counters (range 1..64).
REQ-002 SHALL have parameter COUNT_WIDTH, default 32: width of each counter (range 8..64).
REQ-003 SHALL have parameter SATURATE, default 1: 1 = counter holds at all-ones; 0 = counter wraps to 0.
REQ-004 SHALL have localparam CH_WIDTH = max(1, $clog2(CHANNELS)).
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port event_in, input, CHANNELS: single-cycle MAC/FIFO status pulses, one bit per channel.
REQ-008 SHALL have port clear_all, input, 1: synchronous clear of all counters and flags.
REQ-009 SHALL have port rd_req_valid, input, 1: read request valid.
REQ-010 SHALL have port rd_req_ready, output, 1: read request accepted.
REQ-011 SHALL have port rd_req_ch, input, CH_WIDTH: channel index to read.
REQ-012 SHALL have port rd_req_clear, input, 1: clear the channel on read.
REQ-013 SHALL have port rd_resp_valid, output, 1: response valid.
REQ-014 SHALL have port rd_resp_ready, input, 1: response accepted by requester.
REQ-015 SHALL have port rd_resp_data, output, COUNT_WIDTH: counter value.
REQ-016 SHALL have port rd_resp_ovf, output, 1: the channel's sticky overflow flag at read time.
REQ-017 SHALL have port rd_resp_error, output, 1: the requested index was >= CHANNELS.
REQ-018 SHALL have port overflow, output, CHANNELS: per-channel sticky overflow flags.

Function
REQ-019 SHALL sample every event_in bit on every clk edge; each high bit increments its counter by exactly 1.
REQ-020 SHALL, on an increment when the counter is all-ones and SATURATE=1, hold the counter at all-ones and set overflow[ch].
REQ-021 SHALL, on an increment when the counter is all-ones and SATURATE=0, load 0 into the counter and set overflow[ch].
REQ-022 SHALL keep overflow[ch] set until clear_all, or until a clear-on-read of channel ch is accepted.
REQ-023 SHALL implement a two-state FSM with states IDLE and RESP.
REQ-024 SHALL drive rd_req_ready=1 only in IDLE.
REQ-025 SHALL, when rd_req_valid and rd_req_ready are high, register data, ovf and error for the requested channel and move to RESP.
REQ-026 SHALL take the registered data and ovf values from before that cycle's event increment.
REQ-027 SHALL drive rd_resp_valid=1 in RESP, so response latency is 1 cycle after request acceptance.
REQ-028 SHALL hold rd_resp_data, rd_resp_ovf and rd_resp_error stable while rd_resp_valid=1 and rd_resp_ready=0.
REQ-029 SHALL return to IDLE on rd_resp_valid and rd_resp_ready; maximum throughput is one read per 2 cycles.
REQ-030 SHALL, on an accepted request with rd_req_clear=1, clear the counter and flag in the acceptance cycle; a same-cycle event on that channel leaves the counter at 1 and is not lost.
REQ-031 SHALL, on an out-of-range index, return rd_resp_data=0, rd_resp_ovf=0 and rd_resp_error=1, and modify no counter.
REQ-032 SHALL, on clear_all, load every counter with event_in[ch] (0 or 1) and clear every overflow flag.
REQ-033 SHALL give clear_all priority over clear-on-read in the same cycle; a read accepted in that cycle still returns the pre-clear value.
REQ-034 SHALL NOT let clear_all affect a response already registered in RESP.

Reset
REQ-035 SHALL, on rst high, immediately and asynchronously set all counters to 0, overflow to 0, the FSM to IDLE, rd_resp_valid to 0, and rd_resp_data, rd_resp_ovf and rd_resp_error to 0.
REQ-036 SHALL assert rd_req_ready=1 in the first cycle after rst deasserts.
REQ-037 SHALL, on rst asserted during RESP, discard the pending response; no response is produced after reset.

Verification
REQ-038 Bench SHALL cover: 5 pulses on event_in[2], then a read of ch 2 with clear=0 -> data=5, ovf=0, error=0; a second read -> data=5.
REQ-039 Bench SHALL cover: COUNT_WIDTH=8, SATURATE=1, 300 pulses on ch 0 -> data=255, ovf=1, overflow[0]=1; a read with clear=1 -> a following read returns data=0, ovf=0.
REQ-040 Bench SHALL cover: COUNT_WIDTH=8, SATURATE=0, 257 pulses -> data=1, ovf=1.
REQ-041 Bench SHALL cover: counter=7, then clear-on-read accepted in the same cycle as an event on that channel -> response data=7, a next read returns 1.
REQ-042 Bench SHALL cover: CHANNELS=9, read of ch 12 -> error=1, data=0; rd_resp_ready held low 4 cycles -> outputs stable, rd_req_ready=0.
REQ-043 Bench SHALL cover: rst pulsed mid-RESP -> rd_resp_valid=0 at once, all counters 0, and a read of any channel returns 0.
